// File: rtl/ccv_pkg.sv
// Shared card-check package: digit width, default frame size, FSM state encoding
// and the Luhn doubling map. Used by both the streamer and the validator.
package ccv_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned MAX_DIGITS = 19;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    SEND
  } state_t;

  // d -> 2d, folded back into 0..9 by subtracting 9 (digit sum of 2d)
  function automatic logic [DIGIT_W-1:0] luhn_dbl(input logic [DIGIT_W-1:0] d);
    logic [DIGIT_W:0] t;
    t = {d, 1'b0};
    if (t > 5'd9) t = t - 5'd9;
    return t[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/luhn_acc.sv
// Mod-10 dual accumulator: S0 doubles even-index digits, S1 doubles odd-index
// digits. A clear together with an add starts a fresh sum from that digit.
module luhn_acc
  import ccv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               add,
  input  logic               parity,
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] s0,
  output logic [DIGIT_W-1:0] s1
);

  logic [DIGIT_W-1:0] base0, base1, a0, a1, n0, n1;

  function automatic logic [DIGIT_W-1:0] add_mod10(input logic [DIGIT_W-1:0] a,
                                                   input logic [DIGIT_W-1:0] b);
    logic [DIGIT_W:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t > 5'd9) t = t - 5'd10;
    return t[DIGIT_W-1:0];
  endfunction

  always_comb begin
    base0 = clr ? '0 : s0;
    base1 = clr ? '0 : s1;
    a0    = parity ? digit : luhn_dbl(digit);
    a1    = parity ? luhn_dbl(digit) : digit;
    n0    = add ? add_mod10(base0, a0) : base0;
    n1    = add ? add_mod10(base1, a1) : base1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= n0;
      s1 <= n1;
    end
  end

endmodule

// File: rtl/luhn_digit_streamer.sv
// Accepts a BCD payload (MSD first), appends its Luhn check digit and streams the
// frame out one digit per handshake. LUHN_ERR_INJECT_EN adds err_inject (check+1).
module luhn_digit_streamer #(
  parameter int unsigned MAX_DIGITS = ccv_pkg::MAX_DIGITS,
  parameter int unsigned DW         = ccv_pkg::DIGIT_W,
  parameter int unsigned CW         = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_digit,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] out_digit,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
`ifdef LUHN_ERR_INJECT_EN
  input  logic          err_inject,
`endif
  output logic [DW-1:0] check_digit,
  output logic          busy,
  output logic          err
);

  import ccv_pkg::*;

  localparam int unsigned   PAY_MAX = MAX_DIGITS - 1;
  localparam logic [CW-1:0] OVF_LEN = CW'(MAX_DIGITS - 2);

  state_t        state_q, state_d;
  logic [DW-1:0] dig_buf [PAY_MAX];
  logic [CW-1:0] len_q, rd_q, wr_idx;
  logic [DW-1:0] check_q, s0, s1, s_sel, check_c, check_tx;
  logic          err_q, accept, bad, tx_beat, at_check, inject;

`ifdef LUHN_ERR_INJECT_EN
  assign inject = err_inject;
`else
  assign inject = 1'b0;
`endif

  // len_q still holds the previous frame's length in IDLE, so the first digit indexes from 0
  assign wr_idx   = (state_q == IDLE) ? '0 : len_q;
  assign in_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept   = in_valid && in_ready;
  assign bad      = accept && ((in_digit > DW'(9)) || (!in_last && (wr_idx == OVF_LEN)));

  assign at_check  = (rd_q == len_q);
  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && at_check;
  assign out_digit = !out_valid ? '0 : (at_check ? check_q : dig_buf[rd_q]);
  assign tx_beat   = out_valid && out_ready;

  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign check_digit = check_q;

  luhn_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == IDLE),
    .add   (accept),
    .parity(wr_idx[0]),
    .digit (in_digit),
    .s0    (s0),
    .s1    (s1)
  );

  always_comb begin
    s_sel    = len_q[0] ? s0 : s1;
    check_c  = (s_sel == '0) ? '0 : DW'(10) - s_sel;
    check_tx = check_c;
    if (inject) check_tx = (check_c == DW'(9)) ? '0 : check_c + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: if (accept) state_d = bad ? IDLE : (in_last ? CALC : LOAD);
      CALC:       state_d = SEND;
      SEND:       if (tx_beat && at_check) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      rd_q    <= '0;
      check_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < PAY_MAX; i++) dig_buf[i] <= '0;
    end else begin
      err_q <= bad;
      if (accept) len_q <= wr_idx + 1'b1;
      if (accept && !bad) dig_buf[wr_idx] <= in_digit;
      if (state_q == CALC) begin
        rd_q    <= '0;
        check_q <= check_tx;
      end else if (tx_beat && !at_check) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

endmodule
